// File: rtl/median_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : median_frame_ctrl_if
// Description : Bundles the frame control, upstream pixel stream, core
//               pipeline and downstream pixel stream signals of the median
//               frame sequencer.
//               slave  : sequencer view (drives busy/done/in_ready/core_en/
//                        core_din/out_pixel/out_valid/col/row)
//               master : environment view (drives start/in_pixel/in_valid/
//                        core_pixel/out_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface median_frame_ctrl_if #(
    parameter int CW = 10
);
    logic          start;
    logic          busy;
    logic          done;
    logic [7:0]    in_pixel;
    logic          in_valid;
    logic          in_ready;
    logic          core_en;
    logic [7:0]    core_din;
    logic [7:0]    core_pixel;
    logic [7:0]    out_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] col;
    logic [CW-1:0] row;

    modport slave (
        input  start, in_pixel, in_valid, core_pixel, out_ready,
        output busy, done, in_ready, core_en, core_din, out_pixel, out_valid,
               col, row
    );

    modport master (
        output start, in_pixel, in_valid, core_pixel, out_ready,
        input  busy, done, in_ready, core_en, core_din, out_pixel, out_valid,
               col, row
    );
endinterface
`default_nettype wire

// File: rtl/median_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : median_frame_ctrl
// Description : Frame-level sequencer for the 3x3 median core. Accepts a
//               raster pixel stream, advances the core only on accepted
//               pixels or flush beats, tags results coming from complete
//               3x3 windows and forwards only those downstream with
//               valid/ready back-pressure.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - median_frame_ctrl_if.slave (control, upstream,
//                      core and downstream signals)
// Revision    : 1.0 - initial release
// ============================================================================
module median_frame_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int PIPE_LAT = 3,
    parameter int CW       = 10
) (
    input  logic               clk,
    input  logic               rst,
    median_frame_ctrl_if.slave bus
);

    localparam int                c_fcw        = $clog2(PIPE_LAT + 1);
    localparam logic [CW-1:0]     c_last_col   = CW'(IMG_W - 1);
    localparam logic [CW-1:0]     c_last_row   = CW'(IMG_H - 1);
    localparam logic [CW-1:0]     c_win_min    = CW'(2);
    localparam logic [c_fcw-1:0]  c_flush_init = c_fcw'(PIPE_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_col;
    logic [CW-1:0]       r_row;
    logic [PIPE_LAT-1:0] r_tag;
    logic                r_taken;
    logic [c_fcw-1:0]    r_flush_cnt;
    logic                r_busy;
    logic                r_done;

    logic                w_out_valid;
    logic                w_stall;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_adv;
    logic                w_new_tag;
    logic [PIPE_LAT-1:0] w_tag_next;

    // r_tag mirrors the core pipeline: bit PIPE_LAT-1 belongs to the result
    // currently sitting on core_pixel. r_taken remembers that this result
    // was already handed off while the core was frozen.
    assign w_out_valid = r_tag[PIPE_LAT-1] & ~r_taken;
    assign w_stall     = w_out_valid & ~bus.out_ready;
    assign w_in_ready  = (r_state == S_RUN) & ~w_stall;
    assign w_accept    = w_in_ready & bus.in_valid;
    assign w_adv       = ~w_stall & (((r_state == S_RUN) & bus.in_valid) |
                                     ((r_state == S_FLUSH) & (r_flush_cnt != '0)));

    // Flush beats push a zero tag because w_accept is low outside RUN.
    assign w_new_tag   = w_accept & (r_row >= c_win_min) & (r_col >= c_win_min);

    generate
        if (PIPE_LAT == 1) begin : g_tag_single
            assign w_tag_next = w_new_tag;
        end else begin : g_tag_shift
            assign w_tag_next = {r_tag[PIPE_LAT-2:0], w_new_tag};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_tag       <= '0;
            r_taken     <= 1'b0;
            r_flush_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_adv) begin
                r_tag   <= w_tag_next;
                r_taken <= 1'b0;
            end else if (w_out_valid & bus.out_ready) begin
                r_taken <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_tag   <= '0;
                        r_taken <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (w_accept) begin
                        if (r_col == c_last_col) begin
                            r_col <= '0;
                            if (r_row == c_last_row) begin
                                r_row       <= '0;
                                r_flush_cnt <= c_flush_init;
                                r_state     <= S_FLUSH;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end

                S_FLUSH: begin
                    if (w_adv) begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                    // Leave only once the pipe is pushed through and the
                    // final result has been handed off.
                    if ((r_flush_cnt == '0) && !w_out_valid) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.in_ready  = w_in_ready;
    assign bus.core_en   = w_adv;
    assign bus.core_din  = (r_state == S_RUN) ? bus.in_pixel : 8'd0;
    assign bus.out_pixel = bus.core_pixel;
    assign bus.out_valid = w_out_valid;
    assign bus.col       = r_col;
    assign bus.row       = r_row;

endmodule
`default_nettype wire

// File: doc/median_frame_ctrl.md
Name: median_frame_ctrl

Overview:
Frame-level sequencer for the 3x3 median pipeline datapath (the "core"). It accepts a raster pixel stream with a valid/ready handshake and advances the core pipeline only on accepted pixels or flush beats. It tracks row/column to tag which core results come from complete 3x3 windows. It delivers only those results downstream with valid/ready back-pressure, producing an (IMG_W-2)x(IMG_H-2) output image per start.

Parameters:
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
PIPE_LAT, 3, core latency in core_en beats from a pixel entering to its window result at core_pixel (>=1)
CW, 10, width of row/column counters (2^CW > max(IMG_W, IMG_H))

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin one frame; sampled only in IDLE
busy  out  1  high in RUN and FLUSH
done  out  1  one-cycle pulse when the frame is fully drained
in_pixel  in  8  upstream pixel
in_valid  in  1  upstream valid
in_ready  out  1  upstream ready
core_en  out  1  core pipeline advance strobe
core_din  out  8  pixel to core; in_pixel in RUN, 8'd0 in FLUSH
core_pixel  in  8  core median result
out_pixel  out  8  downstream pixel, equal to core_pixel
out_valid  out  1  downstream valid
out_ready  in  1  downstream ready
col  out  CW  column of the next pixel to accept
row  out  CW  row of the next pixel to accept

Behaviour:
- Clock clk. Reset rst is synchronous and active-high, and takes priority over everything. On reset: state=IDLE; col=row=0; tag register=0; taken=0; flush_cnt=0. All outputs are 0: busy, done, in_ready, core_en, out_valid.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: when start=1, clear col, row, tag and taken, then go to RUN. start is ignored in every other state.
- stall = out_valid & ~out_ready.
- in_ready = (state==RUN) & ~stall. This is combinational and does not depend on in_valid.
- adv = ~stall & ((state==RUN & in_valid) | (state==FLUSH & flush_cnt!=0)).
- core_en = adv.
- Column/row counting on an accepted pixel (RUN & in_valid & in_ready):
  - col increments.
  - When col==IMG_W-1: col wraps to 0 and row increments.
  - When the pixel at (IMG_H-1, IMG_W-1) is accepted: go to FLUSH with flush_cnt=PIPE_LAT, and set row=col=0.
- Window tag for an accepted pixel = (row>=2) & (col>=2), using the counters before update. FLUSH beats use tag 0.
- Tag register: PIPE_LAT bits. On adv it shifts in the new tag; it holds otherwise.
- out_valid = tag[PIPE_LAT-1] & ~taken.
- taken: set on the output handshake (out_valid & out_ready) when adv=0; cleared on any adv. This guarantees each result is delivered exactly once.
- out_pixel = core_pixel. It is stable while stalled because the core is frozen.
- FLUSH: flush_cnt decrements on each adv. When flush_cnt==0 and out_valid==0, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: a complete-window result is offered exactly PIPE_LAT adv beats after its last pixel is accepted.
- Simultaneous events:
  - An output handshake and adv in the same cycle are legal; the next result is presented on the following cycle.
  - in_valid while stalled: not accepted, core frozen, counters hold.
- Reset mid-frame: aborts the frame immediately. No done pulse; partial results are discarded.
- Output count per frame is exactly (IMG_W-2)*(IMG_H-2).

Test Plan:
- IMG_W=4, IMG_H=4, PIPE_LAT=3; start; 16 pixels 0..15 with in_valid=1 and out_ready=1 held -> exactly 4 out_valid beats, corresponding to accepted pixel indices 10, 11, 14, 15. The last output comes 3 adv beats after index 15. done pulses once and busy falls in the same cycle.
- Same frame with out_ready low for 5 cycles while out_valid=1 -> in_ready=0, core_en=0, and out_pixel held constant. When out_ready returns, no output is lost or duplicated; the total is 4.
- in_valid toggling 1/0 every cycle -> core_en only on accepted beats; col/row advance only on acceptance; output indices are unchanged.
- start asserted during RUN -> ignored, with no counter reset. After DONE, a second start runs a second frame with identical output sequencing.
- rst asserted after 7 accepted pixels -> next cycle: IDLE, busy=0, out_valid=0, col=row=0. No done pulse. A fresh start gives a clean 4-output frame.
- Default parameters, 307200 pixels with random in_valid/out_ready -> exactly 638*478=304964 outputs, in order, and exactly one done pulse.
